// File: rtl/glb_dual_port_arbiter.sv
// Shares one negedge-sampled dual-port GLB RAM between N_REQ clients: up to two
// round-robin grants per cycle, same-address hazard blocking, tagged read return.
module glb_dual_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR       = $clog2(DEPTH),
  parameter int N_REQ      = 4
) (
  input  logic                        core_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR-1:0]       req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata_a,
  output logic [DATA_WIDTH-1:0]       rsp_rdata_b,
  output logic [N_REQ-1:0]            rsp_port,
  output logic                        ram_we_a,
  output logic                        ram_re_a,
  output logic [ADDR-1:0]             ram_addr_a,
  output logic [DATA_WIDTH-1:0]       ram_wdata_a,
  input  logic [DATA_WIDTH-1:0]       ram_rdata_a,
  output logic                        ram_we_b,
  output logic                        ram_re_b,
  output logic [ADDR-1:0]             ram_addr_b,
  output logic [DATA_WIDTH-1:0]       ram_wdata_b,
  input  logic [DATA_WIDTH-1:0]       ram_rdata_b
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [IDXW-1:0] idx_t;

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [ADDR-1:0]       addr;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  typedef struct packed {
    logic vld;
    logic rd;
    idx_t idx;
  } tag_t;

  function automatic idx_t rot(input idx_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return idx_t'(s);
  endfunction

  function automatic ram_cmd_t issue(input logic g, input logic we,
                                     input logic [ADDR-1:0] addr,
                                     input logic [DATA_WIDTH-1:0] wdata,
                                     input ram_cmd_t prev);
    ram_cmd_t c;
    c    = prev;
    c.we = 1'b0;
    c.re = 1'b0;
    if (g) c = '{we: we, re: !we, addr: addr, wdata: wdata};
    return c;
  endfunction

  idx_t                  rr_ptr_q, rr_ptr_d;
  idx_t                  scan_idx  [N_REQ];
  logic [ADDR-1:0]       addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];
  logic                  grant_a, grant_b;
  idx_t                  win_a, win_b;
  ram_cmd_t              ram_a_q, ram_a_d, ram_b_q, ram_b_d;
  tag_t                  tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d, rsp_port_q, rsp_port_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_a_q, rsp_rdata_a_d, rsp_rdata_b_q, rsp_rdata_b_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR +: ADDR];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      scan_idx[i]  = rot(rr_ptr_q, i);
    end
  end

  // Scan from rr_ptr: first valid takes port A; the next valid requester that
  // does not collide with A (same address with a write involved) takes port B.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_a = 1'b0;
    grant_b = 1'b0;
    win_a   = '0;
    win_b   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_valid[scan_idx[k]]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          win_a   = scan_idx[k];
        end else if (!grant_b &&
                     !((addr_arr[scan_idx[k]] == addr_arr[win_a]) &&
                       (req_we[scan_idx[k]] || req_we[win_a]))) begin
          grant_b = 1'b1;
          win_b   = scan_idx[k];
        end
      end
    end
    // Reset also masks grants so nothing looks accepted while rst_n is low.
    if (!(en && rst_n)) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[win_a] = 1'b1;
    if (grant_b) req_ready[win_b] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_b)      rr_ptr_d = rot(win_b, 1);
    else if (grant_a) rr_ptr_d = rot(win_a, 1);

    ram_a_d = issue(grant_a, req_we[win_a], addr_arr[win_a], wdata_arr[win_a], ram_a_q);
    ram_b_d = issue(grant_b, req_we[win_b], addr_arr[win_b], wdata_arr[win_b], ram_b_q);
    tag_a_d = '{vld: grant_a, rd: !req_we[win_a], idx: win_a};
    tag_b_d = '{vld: grant_b, rd: !req_we[win_b], idx: win_b};
  end

  // Return stage: RAM read data is valid one cycle after issue.
  always_comb begin
    rsp_valid_d   = '0;
    rsp_port_d    = '0;
    rsp_rdata_a_d = rsp_rdata_a_q;
    rsp_rdata_b_d = rsp_rdata_b_q;
    if (tag_a_q.vld && tag_a_q.rd) begin
      rsp_valid_d[tag_a_q.idx] = 1'b1;
      rsp_rdata_a_d            = ram_rdata_a;
    end
    if (tag_b_q.vld && tag_b_q.rd) begin
      rsp_valid_d[tag_b_q.idx] = 1'b1;
      rsp_port_d[tag_b_q.idx]  = 1'b1;
      rsp_rdata_b_d            = ram_rdata_b;
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      ram_a_q       <= '0;
      ram_b_q       <= '0;
      tag_a_q       <= '0;
      tag_b_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_port_q    <= '0;
      rsp_rdata_a_q <= '0;
      rsp_rdata_b_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      rr_ptr_q      <= rr_ptr_d;
      ram_a_q       <= ram_a_d;
      ram_b_q       <= ram_b_d;
      tag_a_q       <= tag_a_d;
      tag_b_q       <= tag_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_port_q    <= rsp_port_d;
      rsp_rdata_a_q <= rsp_rdata_a_d;
      rsp_rdata_b_q <= rsp_rdata_b_d;
    end
  end

  assign ram_we_a    = ram_a_q.we;
  assign ram_re_a    = ram_a_q.re;
  assign ram_addr_a  = ram_a_q.addr;
  assign ram_wdata_a = ram_a_q.wdata;
  assign ram_we_b    = ram_b_q.we;
  assign ram_re_b    = ram_b_q.re;
  assign ram_addr_b  = ram_b_q.addr;
  assign ram_wdata_b = ram_b_q.wdata;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_port    = rsp_port_q;
  assign rsp_rdata_a = rsp_rdata_a_q;
  assign rsp_rdata_b = rsp_rdata_b_q;

  a_one_port_per_req: assert property (@(posedge core_clk) disable iff (!rst_n)
    !(tag_a_q.vld && tag_b_q.vld && (tag_a_q.idx == tag_b_q.idx)));

endmodule

// File: tb/tb_glb_dual_port_arbiter.sv
// Directed bench for glb_dual_port_arbiter with a RAM model, a rule-level
// reference model checked every cycle, and hand-computed pinned expectations.
module tb_glb_dual_port_arbiter;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int N     = 4;

  logic            core_clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid, rsp_port;
  logic [DW-1:0]   rsp_rdata_a, rsp_rdata_b;
  logic            ram_we_a, ram_re_a, ram_we_b, ram_re_b;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 core_clk = ~core_clk;

  glb_dual_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR(AW), .N_REQ(N)) dut (
    .core_clk(core_clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata_a(rsp_rdata_a), .rsp_rdata_b(rsp_rdata_b), .rsp_port(rsp_port),
    .ram_we_a(ram_we_a), .ram_re_a(ram_re_a), .ram_addr_a(ram_addr_a),
    .ram_wdata_a(ram_wdata_a), .ram_rdata_a(ram_rdata_a),
    .ram_we_b(ram_we_b), .ram_re_b(ram_re_b), .ram_addr_b(ram_addr_b),
    .ram_wdata_b(ram_wdata_b), .ram_rdata_b(ram_rdata_b)
  );

  // NOTE: the RAM array has no reset; its contents survive rst_n like real SRAM.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(negedge core_clk) begin
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_wdata_a;
    if (ram_re_a) ram_rdata_a <= ram_mem[ram_addr_a];
    if (ram_we_b) ram_mem[ram_addr_b] <= ram_wdata_b;
    if (ram_re_b) ram_rdata_b <= ram_mem[ram_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            vld;
    bit            we;
    int            idx;
    int            addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } acc_t;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr;
  acc_t          s1 [2];  // issued to the RAM this cycle, per port
  acc_t          s2 [2];  // responses due this cycle, per port

  function automatic int addr_of(input int i);
    return int'(req_addr[i*AW +: AW]);
  endfunction

  function automatic bit clash(input int x, input int y);
    return (addr_of(x) == addr_of(y)) && (req_we[x] || req_we[y]);
  endfunction

  function automatic void model_grant(output int ga, output int gb);
    int order[$];
    ga = -1;
    gb = -1;
    if (!(rst_n && en)) return;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    if (order.size() == 0) return;
    ga = order[0];
    for (int k = 1; k < order.size(); k++)
      if (!clash(order[k], ga)) begin
        gb = order[k];
        break;
      end
  endfunction

  function automatic acc_t make_acc(input int g);
    acc_t a;
    a.vld   = (g >= 0);
    a.we    = 1'b0;
    a.idx   = g;
    a.addr  = 0;
    a.wdata = '0;
    a.rdata = '0;
    if (g >= 0) begin
      a.we    = req_we[g];
      a.addr  = addr_of(g);
      a.wdata = req_wdata[g*DW +: DW];
      a.rdata = m_mem[a.addr];
    end
    return a;
  endfunction

  always @(negedge core_clk) begin
    int            ga, gb;
    logic [N-1:0]  exp_rdy, exp_rv;
    acc_t          na, nb;
    #2;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ram_ctl", {ram_we_a, ram_re_a, ram_we_b, ram_re_b}, 0);
      m_ptr = 0;
      for (int p = 0; p < 2; p++) begin
        s1[p].vld = 1'b0;
        s2[p].vld = 1'b0;
      end
    end else begin
      model_grant(ga, gb);
      exp_rdy = '0;
      if (ga >= 0) exp_rdy[ga] = 1'b1;
      if (gb >= 0) exp_rdy[gb] = 1'b1;
      check("req_ready", req_ready, exp_rdy);

      check("ram_ctl", {ram_we_a, ram_re_a, ram_we_b, ram_re_b},
            {s1[0].vld && s1[0].we, s1[0].vld && !s1[0].we,
             s1[1].vld && s1[1].we, s1[1].vld && !s1[1].we});
      if (s1[0].vld) check("ram_addr_a", ram_addr_a, s1[0].addr);
      if (s1[1].vld) check("ram_addr_b", ram_addr_b, s1[1].addr);
      if (s1[0].vld && s1[0].we) check("ram_wdata_a", ram_wdata_a, s1[0].wdata);
      if (s1[1].vld && s1[1].we) check("ram_wdata_b", ram_wdata_b, s1[1].wdata);

      exp_rv = '0;
      for (int p = 0; p < 2; p++)
        if (s2[p].vld && !s2[p].we) exp_rv[s2[p].idx] = 1'b1;
      check("rsp_valid", rsp_valid, exp_rv);
      for (int p = 0; p < 2; p++)
        if (s2[p].vld && !s2[p].we) begin
          check("rsp_port", rsp_port[s2[p].idx], p);
          check("rsp_rdata", (p == 0) ? rsp_rdata_a : rsp_rdata_b, s2[p].rdata);
        end

      // Advance: reads see all writes accepted in earlier cycles.
      s2 = s1;
      na = make_acc(ga);
      nb = make_acc(gb);
      s1[0] = na;
      s1[1] = nb;
      if (na.vld && na.we) m_mem[na.addr] = na.wdata;
      if (nb.vld && nb.we) m_mem[nb.addr] = nb.wdata;
      if (gb >= 0)      m_ptr = (gb + 1) % N;
      else if (ga >= 0) m_ptr = (ga + 1) % N;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge core_clk);
    #2;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input int addr, input logic [DW-1:0] wd);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] pre [DEPTH];
    pre = '{16'h0A0A, 16'h1234, 16'h2222, 16'h3333};
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = pre[i];
      m_mem[i]   = pre[i];
    end
    rst_n = 1'b0;
    en    = 1'b1;
    idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, '0);

    // Reset held with every requester valid
    mid();
    check("pin_rst_ready", req_ready, 4'b0000);
    check("pin_rst_ram", {ram_we_a, ram_re_a, ram_we_b, ram_re_b}, 4'b0000);
    check("pin_rst_rsp", rsp_valid, 4'b0000);
    step(); mid(); step();

    // Release: requesters 0 and 1 take ports A and B
    rst_n = 1'b1;
    idle();
    set_req(0, 1'b0, 0, '0);
    set_req(1, 1'b0, 1, '0);
    mid();
    check("pin_first_grant", req_ready, 4'b0011);
    step(); idle(); mid(); step(); mid();
    check("pin_first_rsp", rsp_valid, 4'b0011);
    check("pin_first_rdata_a", rsp_rdata_a, 16'h0A0A);
    check("pin_first_rdata_b", rsp_rdata_b, 16'h1234);
    step();

    // Round-robin: pointer is 2, so pairs alternate {2,3},{0,1},...
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, '0);
    for (int c = 0; c < 4; c++) begin
      mid();
      check("pin_rr_grant", req_ready, (c % 2 == 0) ? 4'b1100 : 4'b0011);
      if (c == 2) begin
        check("pin_rr_rsp", rsp_valid, 4'b1100);
        check("pin_rr_rdata_a", rsp_rdata_a, 16'h2222);
        check("pin_rr_rdata_b", rsp_rdata_b, 16'h3333);
      end
      step();
    end
    idle();
    mid(); step(); mid(); step();

    // Write hazard: 0 writes addr 2 while 1 reads addr 2
    set_req(0, 1'b1, 2, 16'hABCD);
    set_req(1, 1'b0, 2, '0);
    mid();
    check("pin_hz_grant0", req_ready, 4'b0001);
    step();
    req_valid[0] = 1'b0;
    mid();
    check("pin_hz_grant1", req_ready, 4'b0010);
    step(); idle(); mid();
    check("pin_hz_no_wr_rsp", rsp_valid, 4'b0000);
    step(); mid();
    check("pin_hz_rsp", rsp_valid, 4'b0010);
    check("pin_hz_port", rsp_port[1], 1'b0);
    check("pin_hz_rdata", rsp_rdata_a, 16'hABCD);
    step();

    // Read sharing: 2 and 3 both read addr 1
    set_req(2, 1'b0, 1, '0);
    set_req(3, 1'b0, 1, '0);
    mid();
    check("pin_share_grant", req_ready, 4'b1100);
    step(); idle(); mid(); step(); mid();
    check("pin_share_rsp", rsp_valid, 4'b1100);
    check("pin_share_rdata_a", rsp_rdata_a, 16'h1234);
    check("pin_share_rdata_b", rsp_rdata_b, 16'h1234);
    step();

    // en low for 3 cycles right after a read is accepted
    set_req(1, 1'b0, 3, '0);
    mid();
    check("pin_en_pre_grant", req_ready, 4'b0010);
    step();
    en = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, '0);
    for (int c = 0; c < 3; c++) begin
      mid();
      check("pin_en_low_ready", req_ready, 4'b0000);
      if (c == 1) begin
        check("pin_en_low_rsp", rsp_valid, 4'b0010);
        check("pin_en_low_rdata", rsp_rdata_a, 16'h3333);
      end
      step();
    end
    en = 1'b1;
    mid();
    check("pin_en_ptr_kept", req_ready, 4'b1100);
    step(); idle();
    mid(); step(); mid(); step();

    // Reset one cycle after a read is accepted
    set_req(0, 1'b1, 0, 16'h5A5A);
    mid();
    check("pin_mr_wr_grant", req_ready, 4'b0001);
    step(); idle();
    set_req(1, 1'b0, 2, '0);
    mid();
    check("pin_mr_rd_grant", req_ready, 4'b0010);
    step();
    rst_n = 1'b0;
    idle();
    mid();
    check("pin_mr_rsp_rst", rsp_valid, 4'b0000);
    step();
    rst_n = 1'b1;
    mid();
    check("pin_mr_rsp_dropped", rsp_valid, 4'b0000);
    step(); mid();
    check("pin_mr_rsp_late", rsp_valid, 4'b0000);
    step();
    set_req(0, 1'b0, 0, '0);
    mid();
    check("pin_mr_post_grant", req_ready, 4'b0001);
    step(); idle(); mid(); step(); mid();
    check("pin_mr_post_rsp", rsp_valid, 4'b0001);
    check("pin_mr_post_rdata", rsp_rdata_a, 16'h5A5A);
    step(); mid(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glb_dual_port_arbiter.md
# glb_dual_port_arbiter

- Shares one dual-port GLB RAM (two independent read/write ports, negedge-sampled, `DEPTH` words) between `N_REQ` requesters, for example the ifmap filler, the psum reader and the psum writer.
- Each cycle it grants up to two requests by round-robin, one per RAM port, and registers the RAM control signals.
- It blocks same-address hazards between the two ports and returns read data to the requester that issued the read, tagged one-hot.
- It sits between the GLB clients and the GLB RAM instance.

## Interface

Parameters:
- `DATA_WIDTH`, 16: RAM word width.
- `DEPTH`, 4: RAM words.
- `ADDR`, `$clog2(DEPTH)`: address width.
- `N_REQ`, 4: requester count, at least 2.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `core_clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: when 0, no new grants are issued; in-flight reads still return.
- `req_valid` in `N_REQ`: request pending, one bit per requester.
- `req_we` in `N_REQ`: 1 = write, 0 = read.
- `req_addr` in `N_REQ*ADDR`: packed; requester i at `[i*ADDR +: ADDR]`.
- `req_wdata` in `N_REQ*DATA_WIDTH`: packed, same scheme.
- `req_ready` out `N_REQ`: combinational grant; a transfer occurs on a posedge where `req_valid[i] & req_ready[i]`.
- `rsp_valid` out `N_REQ`: one-hot per returned read, one cycle each.
- `rsp_rdata_a` out `DATA_WIDTH`: port-A read data.
- `rsp_rdata_b` out `DATA_WIDTH`: port-B read data.
- `rsp_port` out `N_REQ`: per requester, 0 = take `rsp_rdata_a`, 1 = take `rsp_rdata_b`; meaningful only where `rsp_valid` is set.
- `ram_we_a`, `ram_re_a` out 1; `ram_addr_a` out `ADDR`; `ram_wdata_a` out `DATA_WIDTH`: port-A drive.
- `ram_rdata_a` in `DATA_WIDTH`: port-A read data from the RAM.
- `ram_we_b`, `ram_re_b`, `ram_addr_b`, `ram_wdata_b`, `ram_rdata_b`: same as port A, for port B.

## Operation

Arbitration is combinational each cycle.
- Scan requesters starting at `rr_ptr`, wrapping modulo `N_REQ`.
- The first valid requester is winner A and goes to port A.
- The next valid requester (continuing the scan) is the candidate for port B.

Hazard rule:
- The B candidate is rejected if its address equals A's address and either of them writes.
- On rejection the scan continues to the next valid non-conflicting requester. If none exists, port B is idle.
- Two reads to the same address are allowed on both ports.

Grants and pointer:
- Grants are issued only when `en`=1.
- `req_ready` is 1 exactly for the granted requesters: at most two bits, none if `en`=0.
- `rr_ptr` advances to (index of last granted requester + 1) mod `N_REQ`. It is unchanged if nothing is granted.

Issue stage (posedge after acceptance):
- Register `ram_*_a/b` from the winners: `we`=`req_we`, `re`=`~req_we`, plus `addr` and `wdata`.
- An ungranted port gets `we`=`re`=0; `addr` and `wdata` hold their previous values.
- A tag register per port records requester index, valid, and is-read.

Return stage:
- On the next posedge, `ram_rdata_a/b` are captured into `rsp_rdata_a/b`.
- `rsp_valid[tag]` is set for each port whose tag was a read.
- Writes produce no response.
- If the same requester got both ports (impossible by construction), this is an assertion error.

Reset values:
- All `ram_we/re` = 0; `ram_addr`/`ram_wdata` = 0.
- `rsp_valid` = 0, `rsp_rdata_a/b` = 0, `rsp_port` = 0.
- `rr_ptr` = 0; tags are invalid.

Reset mid-operation: in-flight reads are dropped with no response, and the RAM contents are untouched.

`en` falling: no grants that cycle; already-issued reads still return.

Requesters must hold address, data and `we` stable while valid and not ready.

## Timing

- Cycle t: `req_valid & req_ready` are sampled at posedge t (end of cycle t).
- Cycle t+1: `ram_*` signals are driven and the RAM samples them on the negedge mid-cycle.
- Cycle t+2: `rsp_valid`/`rsp_rdata` are high for exactly one cycle.
- Read latency is 2 cycles from acceptance.
- Write data is in the RAM after the negedge of t+1.
- Read-after-write to the same address, accepted in consecutive cycles, returns the new data: the write lands at negedge t+1, the read at negedge t+2.
- A write and a read to the same address in the same cycle never occur (hazard rule).
- Throughput: 2 accesses per cycle sustained when no hazards exist.

## Test plan

- Reset behaviour: hold `rst_n`=0 while all requests are valid. Required: `req_ready`=0, all `ram_we/re`=0, `rsp_valid`=0. Release reset with requesters 0 and 1 valid: requester 0 is granted port A and requester 1 port B in the first cycle.
- Round-robin: all 4 requesters continuously read distinct addresses 0..3. Required: grant pairs {0,1}, {2,3}, {0,1}…, and each requester gets `rsp_valid` exactly 2 cycles after each grant, with correct data.
- Write hazard: requester 0 writes addr 2 = 0xABCD while requester 1 reads addr 2. Required: only requester 0 granted; requester 1 granted the next cycle and receives 0xABCD.
- Read sharing: requesters 2 and 3 both read addr 1 (preloaded 0x1234). Required: both granted the same cycle; `rsp_valid`=4'b1100, `rsp_rdata_a`=`rsp_rdata_b`=0x1234.
- `en` low: `en`=0 for 3 cycles with a read already issued the cycle before. Required: the pending response still appears, no `req_ready` during those 3 cycles, and `rr_ptr` is unchanged.
- Reset mid-read: assert `rst_n` low 1 cycle after a read is accepted. Required: no `rsp_valid` ever for that read, and a previously written value is still readable after reset.
